// File: rtl/button_event_classifier.sv
// -----------------------------------------------------------------------------
// button_event_classifier
//   Turns the debounced, clock-synchronous button level into one-cycle event
//   pulses: press, release, short press, long press and auto-repeat while held.
//   One instance per push-button, directly downstream of the debouncer.
//
// Parameters
//   CLOCK_FREQ    clock frequency in Hz (1 ms = CLOCK_FREQ/1000 cycles, >=1000)
//   LONG_PRESS_MS hold time in ms that qualifies a long press (>=1)
//   REPEAT_MS     auto-repeat period in ms after a long press (0 = no repeat)
//   ACTIVE_LOW    1: din low means pressed; 0: din high means pressed
//
// Ports
//   clk           system clock
//   n_rst         asynchronous active-low reset
//   din           debounced button level
//   press_pulse   1-cycle pulse on press
//   release_pulse 1-cycle pulse on release
//   short_pulse   1-cycle pulse on release before the long-press threshold
//   long_pulse    1-cycle pulse when the hold reaches LONG_PRESS_MS
//   repeat_pulse  1-cycle pulse every REPEAT_MS while held after long_pulse
//   held          registered pressed level (state != IDLE)
//   press_count   presses since reset, wraps 255 -> 0
// -----------------------------------------------------------------------------
module button_event_classifier #(
  parameter int unsigned CLOCK_FREQ    = 24000000,
  parameter int unsigned LONG_PRESS_MS = 1000,
  parameter int unsigned REPEAT_MS     = 200,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       din,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  localparam int unsigned PS_DIV = CLOCK_FREQ / 1000;
  localparam int unsigned PS_W   = (PS_DIV > 1) ? $clog2(PS_DIV) : 1;
  localparam int unsigned MS_MAX = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
  localparam int unsigned MS_W   = $clog2(MS_MAX + 1);

  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PS_DIV - 1);
  localparam logic [MS_W-1:0] LONG_CMP = MS_W'(LONG_PRESS_MS);
  localparam logic [MS_W-1:0] REP_CMP  = MS_W'(REPEAT_MS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_LONG_HELD
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_prev;
  logic [PS_W-1:0] r_presc;
  logic [MS_W-1:0] r_ms_cnt;
  logic            r_press;
  logic            r_release;
  logic            r_short;
  logic            r_long;
  logic            r_repeat;
  logic            r_held;
  logic [7:0]      r_count;

  logic            w_pressed;
  logic            w_tick;
  logic [MS_W-1:0] w_ms_inc;
  logic [PS_W-1:0] w_presc_nxt;
  logic [MS_W-1:0] w_ms_nxt;
  logic            w_press_nxt;
  logic            w_release_nxt;
  logic            w_short_nxt;
  logic            w_long_nxt;
  logic            w_repeat_nxt;

  assign w_pressed = din ^ ACTIVE_LOW;
  // The ms prescaler only runs outside IDLE, so timing always starts from
  // the press edge.
  assign w_tick    = (r_state != S_IDLE) && (r_presc == PS_LAST);
  assign w_ms_inc  = r_ms_cnt + 1'b1;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a release always takes priority over a completing tick
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_pressed && !r_prev) begin
          w_state_nxt = S_PRESSED;
        end
      end
      S_PRESSED: begin
        if (!w_pressed) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick && (w_ms_inc == LONG_CMP)) begin
          w_state_nxt = S_LONG_HELD;
        end
      end
      S_LONG_HELD: begin
        if (!w_pressed) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_short_nxt   = 1'b0;
    w_long_nxt    = 1'b0;
    w_repeat_nxt  = 1'b0;
    w_ms_nxt      = r_ms_cnt;
    if (r_state == S_IDLE) begin
      w_presc_nxt = '0;
    end else if (w_tick) begin
      w_presc_nxt = '0;
    end else begin
      w_presc_nxt = r_presc + 1'b1;
    end

    unique case (r_state)
      S_IDLE: begin
        if (w_pressed && !r_prev) begin
          w_press_nxt = 1'b1;
          w_ms_nxt    = '0;
        end
      end
      S_PRESSED: begin
        if (!w_pressed) begin
          w_release_nxt = 1'b1;
          w_short_nxt   = 1'b1;
        end else if (w_tick) begin
          if (w_ms_inc == LONG_CMP) begin
            w_long_nxt = 1'b1;
            w_ms_nxt   = '0;
          end else begin
            w_ms_nxt   = w_ms_inc;
          end
        end
      end
      S_LONG_HELD: begin
        if (!w_pressed) begin
          w_release_nxt = 1'b1;
        end else if (w_tick && (REPEAT_MS != 0)) begin
          if (w_ms_inc == REP_CMP) begin
            w_repeat_nxt = 1'b1;
            w_ms_nxt     = '0;
          end else begin
            w_ms_nxt     = w_ms_inc;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and counters
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_prev    <= 1'b0;
      r_presc   <= '0;
      r_ms_cnt  <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_prev    <= w_pressed;
      r_presc   <= w_presc_nxt;
      r_ms_cnt  <= w_ms_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_short   <= w_short_nxt;
      r_long    <= w_long_nxt;
      r_repeat  <= w_repeat_nxt;
      r_held    <= (w_state_nxt != S_IDLE);
      if (w_press_nxt) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign short_pulse   = r_short;
  assign long_pulse    = r_long;
  assign repeat_pulse  = r_repeat;
  assign held          = r_held;
  assign press_count   = r_count;

endmodule

// File: tb/tb_button_event_classifier.sv
module tb_button_event_classifier;

  logic clk;
  logic n_rst;

  // main instance: 10 cycles/ms, long = 5 ms, repeat = 2 ms
  logic       din;
  logic       press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;
  logic [7:0] press_count;

  // repeat disabled
  logic       din_nr;
  logic       press_nr, release_nr, short_nr, long_nr, repeat_nr, held_nr;
  logic [7:0] count_nr;

  // active-low input
  logic       din_al;
  logic       press_al, release_al, short_al, long_al, repeat_al, held_al;
  logic [7:0] count_al;

  button_event_classifier #(
    .CLOCK_FREQ(10000), .LONG_PRESS_MS(5), .REPEAT_MS(2), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .n_rst(n_rst), .din(din),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .short_pulse(short_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .held(held),
    .press_count(press_count)
  );

  button_event_classifier #(
    .CLOCK_FREQ(10000), .LONG_PRESS_MS(5), .REPEAT_MS(0), .ACTIVE_LOW(1'b0)
  ) dut_nr (
    .clk(clk), .n_rst(n_rst), .din(din_nr),
    .press_pulse(press_nr), .release_pulse(release_nr), .short_pulse(short_nr),
    .long_pulse(long_nr), .repeat_pulse(repeat_nr), .held(held_nr),
    .press_count(count_nr)
  );

  button_event_classifier #(
    .CLOCK_FREQ(10000), .LONG_PRESS_MS(5), .REPEAT_MS(2), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .n_rst(n_rst), .din(din_al),
    .press_pulse(press_al), .release_pulse(release_al), .short_pulse(short_al),
    .long_pulse(long_al), .repeat_pulse(repeat_al), .held(held_al),
    .press_count(count_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // cycle stamps and event counters, sampled on the falling edge
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_press = 0, n_rel = 0, n_short = 0, n_long = 0, n_rep = 0, n_both = 0;
  int n_viol = 0, n_held_bad = 0;
  int t_press = 0, t_long = 0, t_rel = 0;
  int rep_t[0:63];
  int n_nr_long = 0, n_nr_rep = 0, n_al_press = 0;

  always @(negedge clk) begin
    if (press_pulse) begin n_press++; t_press = cyc; end
    if (release_pulse) begin n_rel++; t_rel = cyc; end
    if (short_pulse) n_short++;
    if (long_pulse) begin n_long++; t_long = cyc; end
    if (repeat_pulse) begin
      if (n_rep < 64) rep_t[n_rep] = cyc;
      n_rep++;
    end
    if (release_pulse && short_pulse) n_both++;
    if ((32'(press_pulse) + 32'(short_pulse) + 32'(long_pulse) + 32'(repeat_pulse)) > 1)
      n_viol++;
    if (release_pulse && (press_pulse || long_pulse || repeat_pulse)) n_viol++;
    if ((press_pulse && !held) || (release_pulse && held)) n_held_bad++;
    if (long_nr) n_nr_long++;
    if (repeat_nr) n_nr_rep++;
    if (press_al) n_al_press++;
  end

  task automatic hold_cycles(input int n);
    @(negedge clk); din = 1'b1;
    repeat (n) @(negedge clk);
    din = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  int s_press, s_rel, s_short, s_long, s_rep, s_both;

  task automatic snap();
    s_press = n_press; s_rel = n_rel; s_short = n_short;
    s_long  = n_long;  s_rep = n_rep; s_both  = n_both;
  endtask

  initial begin
    din = 1'b0; din_nr = 1'b0; din_al = 1'b1;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    // reset state
    check_eq("rst_press", press_pulse, 0);
    check_eq("rst_held", held, 0);
    check_eq("rst_count", press_count, 0);
    check_eq("rst_long", long_pulse, 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: tap of 20 cycles
    snap();
    hold_cycles(20);
    check_eq("tap_press", n_press - s_press, 1);
    check_eq("tap_rel_short", n_both - s_both, 1);
    check_eq("tap_rel", n_rel - s_rel, 1);
    check_eq("tap_long", n_long - s_long, 0);
    check_eq("tap_rel_lat", t_rel - t_press, 20);
    check_eq("tap_count", press_count, 1);
    check_eq("tap_held", held, 0);

    // 2: long hold of 120 cycles
    snap();
    hold_cycles(120);
    check_eq("lh_long", n_long - s_long, 1);
    check_eq("lh_long_lat", t_long - t_press, 50);
    check_eq("lh_rep_n", n_rep - s_rep, 3);
    check_eq("lh_rep1", rep_t[s_rep] - t_press, 70);
    check_eq("lh_rep2", rep_t[s_rep + 1] - t_press, 90);
    check_eq("lh_short", n_short - s_short, 0);
    check_eq("lh_rel", n_rel - s_rel, 1);
    check_eq("lh_count", press_count, 2);

    // 3a: release sampled on the completing tick
    snap();
    hold_cycles(50);
    check_eq("b50_short", n_both - s_both, 1);
    check_eq("b50_long", n_long - s_long, 0);
    // 3b: one cycle longer
    snap();
    hold_cycles(51);
    check_eq("b51_long", n_long - s_long, 1);
    check_eq("b51_long_lat", t_long - t_press, 50);
    check_eq("b51_short", n_short - s_short, 0);
    check_eq("b51_rel", n_rel - s_rel, 1);
    check_eq("b51_rel_lat", t_rel - t_long, 1);
    check_eq("b51_count", press_count, 4);

    // 4: repeat disabled, 200-cycle hold
    @(negedge clk); din_nr = 1'b1;
    repeat (200) @(negedge clk);
    din_nr = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("nr_long", n_nr_long, 1);
    check_eq("nr_rep", n_nr_rep, 0);
    check_eq("nr_count", count_nr, 1);

    // 5: async reset while in LONG_HELD
    snap();
    @(negedge clk); din = 1'b1;
    repeat (60) @(negedge clk);
    check_eq("ar_held_before", held, 1);
    @(posedge clk); #2;
    n_rst = 1'b0;
    #1;
    check_eq("ar_held", held, 0);
    check_eq("ar_count", press_count, 0);
    check_eq("ar_pulses", press_pulse | release_pulse | long_pulse | repeat_pulse | short_pulse, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    check_eq("ar_press", press_pulse, 1);
    check_eq("ar_count_after", press_count, 1);
    @(negedge clk); din = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("ar_no_rel_before_press", n_rel - s_rel, 1);
    check_eq("ar_al_count_rst", count_al, 0);

    // 6: active-low, 256 taps
    begin
      int base;
      base = n_al_press;
      for (int unsigned i = 0; i < 256; i++) begin
        din_al = 1'b0;
        repeat (20) @(negedge clk);
        din_al = 1'b1;
        repeat (20) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check_eq("al_presses", n_al_press - base, 256);
      check_eq("al_count_wrap", count_al, 0);
      check_eq("al_held", held_al, 0);
    end

    check_eq("exclusive_pulses", n_viol, 0);
    check_eq("held_alignment", n_held_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
